// File: rtl/adc_row_col_decoder.sv
// ============================================================================
//  Module   : adc_row_col_decoder
//  Brief    : Registered row/column decoder for a 10-bit SAR capacitor DAC.
//             The 9 MSBs select unit cells in a 16 x 32 matrix; the LSB
//             drives a binary capacitor. All outputs are registered.
//  Options  : ADC_DECODER_INREG_EN - register data_in/row_mode/col_mode
//             ahead of the decode (2-cycle latency instead of 1).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_row_col_decoder (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  data_in,
    input  logic        row_mode,
    input  logic        col_mode,
    output logic [15:0] row_out_n,
    output logic [15:0] rowon_out_n,
    output logic [15:0] rowoff_out_n,
    output logic [31:0] col_out_n,
    output logic [31:0] col_out,
    output logic [2:0]  bincap_out_n,
    output logic        c0p_out_n,
    output logic        c0n_out_n
);

    localparam int          c_ROWS      = 16;
    localparam int          c_COLS      = 32;
    localparam logic [9:0]  c_CODE_MIN  = 10'd0;
    localparam logic [9:0]  c_CODE_MAX  = 10'd1023;

    // ------------------------------------------------------------------
    // Decode source: either the raw ports or a registered copy of them
    // ------------------------------------------------------------------
    logic [9:0] w_data;
    logic       w_row_mode;
    logic       w_col_mode;

`ifdef ADC_DECODER_INREG_EN
    logic [9:0] r_data;
    logic       r_row_mode;
    logic       r_col_mode;

    // Input capture stage; modes come out of reset enabled (thermometer, rowon/rowoff active)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data     <= 10'd0;
            r_row_mode <= 1'b1;
            r_col_mode <= 1'b1;
        end else begin
            r_data     <= data_in;
            r_row_mode <= row_mode;
            r_col_mode <= col_mode;
        end
    end

    assign w_data     = r_data;
    assign w_row_mode = r_row_mode;
    assign w_col_mode = r_col_mode;
`else
    assign w_data     = data_in;
    assign w_row_mode = row_mode;
    assign w_col_mode = col_mode;
`endif

    // ------------------------------------------------------------------
    // Field split: N = data[9:1] unit cells, r = N / 32, c = N % 32
    // ------------------------------------------------------------------
    logic [8:0] w_units;
    logic [3:0] w_row;
    logic [4:0] w_col;

    assign w_units = w_data[9:1];
    assign w_row   = w_units[8:5];
    assign w_col   = w_units[4:0];

    // ------------------------------------------------------------------
    // Next-state decode
    // ------------------------------------------------------------------
    logic [15:0] w_row_n;
    logic [15:0] w_rowon_n;
    logic [15:0] w_rowoff_n;
    logic [31:0] w_col_act;
    logic [2:0]  w_bincap_n;
    logic        w_c0p_n;
    logic        w_c0n_n;

    // Row selects: the partial row is low; rows below it are full, rows above it are empty
    always_comb begin
        w_row_n    = '1;
        w_rowon_n  = '1;
        w_rowoff_n = '1;
        for (int i = 0; i < c_ROWS; i++) begin
            w_row_n[i] = (4'(i) != w_row);
            if (w_row_mode) begin
                w_rowon_n[i]  = !(4'(i) < w_row);
                w_rowoff_n[i] = !(4'(i) > w_row);
            end
        end
    end

    // Column code: thermometer fills columns below c, one-hot marks column c
    always_comb begin
        w_col_act = '0;
        for (int j = 0; j < c_COLS; j++) begin
            if (w_col_mode) begin
                w_col_act[j] = (5'(j) < w_col);
            end else begin
                w_col_act[j] = (5'(j) == w_col);
            end
        end
    end

    // LSB binary cap and end-of-scale dummies; the two upper binary caps are unused
    always_comb begin
        w_bincap_n    = 3'b111;
        w_bincap_n[0] = ~w_data[0];
        w_c0p_n       = (w_data != c_CODE_MIN);
        w_c0n_n       = (w_data != c_CODE_MAX);
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    logic [15:0] r_row_n;
    logic [15:0] r_rowon_n;
    logic [15:0] r_rowoff_n;
    logic [31:0] r_col_n;
    logic [31:0] r_col;
    logic [2:0]  r_bincap_n;
    logic        r_c0p_n;
    logic        r_c0n_n;

    // Register the decode; reset parks every active-low control inactive
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row_n    <= '1;
            r_rowon_n  <= '1;
            r_rowoff_n <= '1;
            r_col_n    <= '1;
            r_col      <= '0;
            r_bincap_n <= '1;
            r_c0p_n    <= 1'b1;
            r_c0n_n    <= 1'b1;
        end else begin
            r_row_n    <= w_row_n;
            r_rowon_n  <= w_rowon_n;
            r_rowoff_n <= w_rowoff_n;
            r_col_n    <= ~w_col_act;
            r_col      <= w_col_act;
            r_bincap_n <= w_bincap_n;
            r_c0p_n    <= w_c0p_n;
            r_c0n_n    <= w_c0n_n;
        end
    end

    assign row_out_n    = r_row_n;
    assign rowon_out_n  = r_rowon_n;
    assign rowoff_out_n = r_rowoff_n;
    assign col_out_n    = r_col_n;
    assign col_out      = r_col;
    assign bincap_out_n = r_bincap_n;
    assign c0p_out_n    = r_c0p_n;
    assign c0n_out_n    = r_c0n_n;

endmodule

`default_nettype wire

// File: tb/tb_adc_row_col_decoder.sv
// ============================================================================
//  Module   : tb_adc_row_col_decoder
//  Brief    : Directed self-checking bench for adc_row_col_decoder.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adc_row_col_decoder;

`ifdef ADC_DECODER_INREG_EN
    localparam int c_LAT = 2;
`else
    localparam int c_LAT = 1;
`endif

    logic        clk;
    logic        rst;
    logic [9:0]  data_in;
    logic        row_mode;
    logic        col_mode;
    logic [15:0] row_out_n;
    logic [15:0] rowon_out_n;
    logic [15:0] rowoff_out_n;
    logic [31:0] col_out_n;
    logic [31:0] col_out;
    logic [2:0]  bincap_out_n;
    logic        c0p_out_n;
    logic        c0n_out_n;

    int n_checks;
    int n_pass;

    adc_row_col_decoder u_dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .row_mode     (row_mode),
        .col_mode     (col_mode),
        .row_out_n    (row_out_n),
        .rowon_out_n  (rowon_out_n),
        .rowoff_out_n (rowoff_out_n),
        .col_out_n    (col_out_n),
        .col_out      (col_out),
        .bincap_out_n (bincap_out_n),
        .c0p_out_n    (c0p_out_n),
        .c0n_out_n    (c0n_out_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply inputs, wait out the pipeline latency, sample #1 after the edge
    task automatic apply(input logic [9:0] d, input logic rm, input logic cm);
        data_in  = d;
        row_mode = rm;
        col_mode = cm;
        repeat (c_LAT) @(posedge clk);
        #1;
    endtask

    // Arithmetic reference model, checked against every output
    task automatic chk_model(input string tag, input logic [9:0] d, input logic rm, input logic cm);
        logic [3:0]  r;
        logic [4:0]  c;
        logic [31:0] t;
        logic [63:0] col_e;
        logic [15:0] on_e;
        logic [15:0] off_e;
        r = d[9:6];
        c = d[5:1];
        t = 32'h1 << r;
        on_e  = rm ? ~(t[15:0] - 16'd1) : 16'hFFFF;
        t = ~(32'hFFFF_FFFE << r);
        off_e = rm ? t[15:0] : 16'hFFFF;
        col_e = cm ? ((64'h1 << c) - 64'd1) : (64'h1 << c);
        t = 32'h1 << r;
        chk({tag, ".row"},    {16'h0, row_out_n},    {16'h0, ~t[15:0]});
        chk({tag, ".rowon"},  {16'h0, rowon_out_n},  {16'h0, on_e});
        chk({tag, ".rowoff"}, {16'h0, rowoff_out_n}, {16'h0, off_e});
        chk({tag, ".col"},    col_out,               col_e[31:0]);
        chk({tag, ".col_n"},  col_out_n,             ~col_e[31:0]);
        chk({tag, ".bincap"}, {29'h0, bincap_out_n}, {29'h0, 2'b11, ~d[0]});
        chk({tag, ".c0p"},    {31'h0, c0p_out_n},    {31'h0, d != 10'd0});
        chk({tag, ".c0n"},    {31'h0, c0n_out_n},    {31'h0, d != 10'd1023});
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        data_in  = 10'h3FF;
        row_mode = 1'b1;
        col_mode = 1'b1;

        // Reset held for two cycles with full-scale input
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            chk("rst.row",    {16'h0, row_out_n},    32'h0000_FFFF);
            chk("rst.rowon",  {16'h0, rowon_out_n},  32'h0000_FFFF);
            chk("rst.rowoff", {16'h0, rowoff_out_n}, 32'h0000_FFFF);
            chk("rst.col_n",  col_out_n,             32'hFFFF_FFFF);
            chk("rst.col",    col_out,               32'h0);
            chk("rst.bincap", {29'h0, bincap_out_n}, 32'h7);
            chk("rst.c0p",    {31'h0, c0p_out_n},    32'h1);
            chk("rst.c0n",    {31'h0, c0n_out_n},    32'h1);
        end
        rst = 1'b0;
        apply(10'h3FF, 1'b1, 1'b1);
        chk("rel.c0n", {31'h0, c0n_out_n},  32'h0);
        chk("rel.row", {16'h0, row_out_n},  32'h0000_7FFF);

        // Full sweep, both modes on
        for (int i = 0; i < 1024; i++) begin
            apply(10'(i), 1'b1, 1'b1);
            chk_model("sweep", 10'(i), 1'b1, 1'b1);
            if (i == 0) begin
                chk("c0.c0p", {31'h0, c0p_out_n}, 32'h0);
                chk("c0.rowoff", {16'h0, rowoff_out_n}, 32'h0000_0001);
                chk("c0.row", {16'h0, row_out_n}, 32'h0000_FFFE);
            end
            if (i == 2) begin
                chk("c2.col",    col_out,               32'h1);
                chk("c2.bincap", {29'h0, bincap_out_n}, 32'h7);
            end
            if (i == 3) chk("c3.bincap", {29'h0, bincap_out_n}, 32'h6);
        end

        // Row wrap 63 -> 64
        apply(10'd63, 1'b1, 1'b1);
        chk("w63.row", {16'h0, row_out_n}, 32'h0000_FFFE);
        chk("w63.col", col_out,            32'h7FFF_FFFF);
        apply(10'd64, 1'b1, 1'b1);
        chk("w64.row",   {16'h0, row_out_n},   32'h0000_FFFD);
        chk("w64.rowon", {16'h0, rowon_out_n}, 32'h0000_FFFE);
        chk("w64.col",   col_out,              32'h0);

        // One-hot columns
        apply(10'd75, 1'b1, 1'b0);
        chk("oh.col",   col_out,   32'h0000_0020);
        chk("oh.col_n", col_out_n, 32'hFFFF_FFDF);
        chk_model("oh", 10'd75, 1'b1, 1'b0);
        apply(10'd0, 1'b1, 1'b0);
        chk("oh0.col", col_out, 32'h0000_0001);

        // Row mode off
        apply(10'd600, 1'b0, 1'b1);
        chk("rm0.rowon",  {16'h0, rowon_out_n},  32'h0000_FFFF);
        chk("rm0.rowoff", {16'h0, rowoff_out_n}, 32'h0000_FFFF);
        chk("rm0.row",    {16'h0, row_out_n},    32'h0000_FDFF);
        chk("rm0.col",    col_out,               32'h0000_0FFF);

        // Top of scale
        apply(10'd1021, 1'b1, 1'b1);
        chk("t1021.bincap", {29'h0, bincap_out_n}, 32'h6);
        chk("t1021.c0n",    {31'h0, c0n_out_n},    32'h1);
        apply(10'd1022, 1'b1, 1'b1);
        chk("t1022.bincap", {29'h0, bincap_out_n}, 32'h7);
        chk("t1022.c0n",    {31'h0, c0n_out_n},    32'h1);
        apply(10'd1023, 1'b1, 1'b1);
        chk("t1023.bincap", {29'h0, bincap_out_n}, 32'h6);
        chk("t1023.c0n",    {31'h0, c0n_out_n},    32'h0);
        chk("t1023.rowon",  {16'h0, rowon_out_n},  32'h0000_8000);
        chk("t1023.rowoff", {16'h0, rowoff_out_n}, 32'h0000_FFFF);
        chk("t1023.col",    col_out,               32'h7FFF_FFFF);

        // Reset mid-stream wins over inputs
        rst = 1'b1;
        data_in = 10'd500;
        @(posedge clk);
        #1;
        chk("rst2.row", {16'h0, row_out_n}, 32'h0000_FFFF);
        chk("rst2.col", col_out,            32'h0);
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/adc_row_col_decoder.md
Name: adc_row_col_decoder

Overview:
- Registered decoder for the 10-bit SAR DAC capacitor code.
- Converts `data_in` into active-low controls for a 16-row x 32-column unit-capacitor matrix (row, row-on, row-off, column).
- Also drives a binary LSB capacitor and two end-of-scale dummy-cap controls.
- Sits between the SAR logic and the capacitor DAC array; all outputs are registered.

Parameters:
- None. Geometry is fixed: 16 rows, 32 columns, 10-bit code.

Ports:
- `clk`  input  1  system clock; all state updates on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `data_in`  input  10  DAC code, unsigned, 0..1023.
- `row_mode`  input  1  1 = drive rowon/rowoff for full/empty rows; 0 = disable them.
- `col_mode`  input  1  1 = thermometer column code; 0 = one-hot column code.
- `row_out_n`  output  16  active-low select of the partially filled row.
- `rowon_out_n`  output  16  active-low "row fully on".
- `rowoff_out_n`  output  16  active-low "row fully off".
- `col_out_n`  output  32  active-low column controls.
- `col_out`  output  32  active-high column controls; always equals ~`col_out_n`.
- `bincap_out_n`  output  3  active-low binary LSB capacitor controls.
- `c0p_out_n`  output  1  active-low zero-code dummy cap.
- `c0n_out_n`  output  1  active-low full-scale dummy cap.
- Interface is one clock; reset is synchronous and active-high.

Behaviour:
- Derived fields: N = `data_in`[9:1] (unit cells, 0..511); r = N[8:5] (0..15); c = N[4:0] (0..31).
- Next-state decode, registered on the rising edge of `clk`; latency 1 cycle from input to output.
- `row_out_n`[i] = 0 iff i == r; exactly one bit low at all times after reset.
- `rowon_out_n`[i] = 0 iff `row_mode` == 1 and i < r.
- `rowoff_out_n`[i] = 0 iff `row_mode` == 1 and i > r.
- `row_mode` == 0: `rowon_out_n` and `rowoff_out_n` all ones.
- `col_out`[j], `col_mode` == 1: 1 iff j < c (thermometer; c = 0 gives all zeros).
- `col_out`[j], `col_mode` == 0: 1 iff j == c (one-hot).
- `col_out_n` = ~`col_out`, bit for bit, every cycle.
- `bincap_out_n`[0] = ~`data_in`[0].
- `bincap_out_n`[2:1] reserved, held at 1.
- `c0p_out_n` = 0 iff `data_in` == 0.
- `c0n_out_n` = 0 iff `data_in` == 1023.
- Reset value of every output register: all `*_n` outputs = all ones; `col_out` = 0.
- Reset overrides input changes in the same cycle; the first decode appears one cycle after `rst` deasserts.
- Boundaries:
  - code 0: r=0, c=0; `row_out_n`=16'hFFFE; `rowon_out_n`=16'hFFFF; `rowoff_out_n`=16'h0001 when `row_mode`=1.
  - code 1023: r=15, c=31; `rowon_out_n`=16'h8000; `rowoff_out_n`=16'hFFFF; thermometer `col_out`=32'h7FFFFFFF.
  - Row wrap at c 31 -> 0 (e.g. code 63 -> 64): r increments and `col_out` clears in the same update.
- Mode inputs are sampled each cycle together with `data_in`; no handshake.

Optional Feature:
- Macro `ADC_DECODER_INREG_EN`.
- Defined: `data_in`, `row_mode` and `col_mode` are registered first, giving 2-cycle latency. Input registers reset to 0 / 1 / 1.
- Not defined: 1-cycle latency as above.

Test Plan:
- `rst`=1 for 2 cycles with `data_in`=10'h3FF:
  - all `*_n` = all ones and `col_out`=0 during reset;
  - after release: `c0n_out_n`=0, `row_out_n`=16'h7FFF.
- Modes=1, sweep `data_in` 0..1023 one per cycle: each output matches the decode of the previous-cycle input. Spot checks:
  - code 0: `c0p_out_n`=0.
  - code 2: `col_out`=32'h1, `bincap_out_n`=3'b111.
  - code 3: `bincap_out_n`=3'b110.
- Modes=1, `data_in`=63 then 64:
  - 63: r=0, `col_out`=32'h7FFFFFFF;
  - 64: `row_out_n`=16'hFFFD, `rowon_out_n`=16'hFFFE, `col_out`=0.
- `col_mode`=0, `data_in`=10'd75 (c=5): `col_out`=32'h20, `col_out_n`=~32'h20.
- `row_mode`=0, `data_in`=10'd600 (r=9): `rowon_out_n`=`rowoff_out_n`=16'hFFFF, `row_out_n`=16'hFDFF.
- Final codes 1021, 1022, 1023 back-to-back:
  - 1021 and 1023: `bincap_out_n`[0]=0;
  - 1022: `bincap_out_n`[0]=1;
  - `c0n_out_n`=0 only for 1023.
